// File: rtl/collision_scanner_if.sv
// collision_scanner_if
// Groups the scan request, the snapshot inputs and the result outputs of
// collision_scanner.
//   master : the game loop (drives start/ship/field, observes results)
//   slave  : the scanner
// Signals:
//   start      request a scan
//   ship       ship occupancy, ship[r][c] = row r, column c
//   field      asteroid occupancy, same indexing
//   busy       high while scanning
//   done       one-cycle pulse when results update
//   hit        at least one overlapping cell
//   hit_row    row of the first overlap (row-major order)
//   hit_col    column of the first overlap
//   hit_count  number of overlapping cells (0 unless COLLISION_COUNT_EN)
interface collision_scanner_if #(
   parameter int ROWS = 16,
   parameter int COLS = 16
);
   localparam int RW = $clog2(ROWS);
   localparam int CW = $clog2(COLS);
   localparam int NW = $clog2(ROWS*COLS+1);

   logic                       start;
   logic [ROWS-1:0][COLS-1:0]  ship;
   logic [ROWS-1:0][COLS-1:0]  field;
   logic                       busy;
   logic                       done;
   logic                       hit;
   logic [RW-1:0]              hit_row;
   logic [CW-1:0]              hit_col;
   logic [NW-1:0]              hit_count;

   modport master (
      output start, ship, field,
      input  busy, done, hit, hit_row, hit_col, hit_count
   );

   modport slave (
      input  start, ship, field,
      output busy, done, hit, hit_row, hit_col, hit_count
   );
endinterface

// File: rtl/collision_scanner.sv
// collision_scanner
// Sequential ship/asteroid collision detector. On an accepted start the two
// occupancy grids are snapshotted, then one row per clock is ANDed and
// checked. The first overlapping cell in row-major order is reported, and
// with COLLISION_COUNT_EN defined the number of overlapping cells as well.
// Every scan takes ROWS SCAN cycles followed by one DONE cycle.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high
//   bus    collision_scanner_if.slave (start/ship/field in, results out)
// Optional feature macro: COLLISION_COUNT_EN (hit_count accumulator).
//
// state   | meaning
// ST_IDLE | waiting for start, results held
// ST_SCAN | evaluating snapshot row r_row, one row per cycle
// ST_DONE | results valid and done high for one cycle; start may restart
module collision_scanner #(
   parameter int ROWS = 16,
   parameter int COLS = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   collision_scanner_if.slave   bus
);
   localparam int RW = $clog2(ROWS);
   localparam int CW = $clog2(COLS);
   localparam int NW = $clog2(ROWS*COLS+1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                     r_state;
   state_t                     w_state_nxt;
   logic                       w_accept;

   logic [ROWS-1:0][COLS-1:0]  r_ship;
   logic [ROWS-1:0][COLS-1:0]  r_field;
   logic [RW-1:0]              r_row;
   logic                       w_last_row;

   logic [COLS-1:0]            w_and_row;
   logic                       w_row_hit;
   logic [CW-1:0]              w_first_col;

   logic                       r_w_hit;
   logic [RW-1:0]              r_w_row;
   logic [CW-1:0]              r_w_col;
   logic                       w_nxt_hit;
   logic [RW-1:0]              w_nxt_row;
   logic [CW-1:0]              w_nxt_col;

   logic                       r_hit;
   logic [RW-1:0]              r_hit_row;
   logic [CW-1:0]              r_hit_col;

   // The row counter stops at ROWS-1 and is reloaded, so it never indexes
   // past the grid even when ROWS is not a power of two.
   assign w_last_row = (r_row == RW'(ROWS-1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.start) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_SCAN;
            end
         end
         ST_SCAN: begin
            if (w_last_row) w_state_nxt = ST_DONE;
         end
         ST_DONE: begin
            if (bus.start) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_SCAN;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign w_and_row = r_ship[r_row] & r_field[r_row];
   assign w_row_hit = |w_and_row;

   // Priority encoder: walking from the top column down leaves the lowest
   // set column index as the final assignment.
   always_comb begin
      w_first_col = '0;
      for (int c = COLS-1; c >= 0; c--) begin
         if (w_and_row[c]) w_first_col = CW'(c);
      end
   end

   // Only the first hitting row of a scan captures coordinates.
   assign w_nxt_hit = r_w_hit | w_row_hit;
   assign w_nxt_row = (w_row_hit && !r_w_hit) ? r_row       : r_w_row;
   assign w_nxt_col = (w_row_hit && !r_w_hit) ? w_first_col : r_w_col;

`ifdef COLLISION_COUNT_EN
   logic [NW-1:0] w_row_pop;
   logic [NW-1:0] r_w_count;
   logic [NW-1:0] r_hit_count;

   always_comb begin
      w_row_pop = '0;
      for (int c = 0; c < COLS; c++) begin
         w_row_pop = w_row_pop + NW'(w_and_row[c]);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_w_count   <= '0;
         r_hit_count <= '0;
      end else if (w_accept) begin
         r_w_count   <= '0;
      end else if (r_state == ST_SCAN) begin
         r_w_count <= r_w_count + w_row_pop;
         if (w_last_row) r_hit_count <= r_w_count + w_row_pop;
      end
   end

   assign bus.hit_count = r_hit_count;
`else
   assign bus.hit_count = {NW{1'b0}};
`endif

   // The result registers load on the edge that enters DONE, using the
   // working values updated with the last row, so they are valid for the
   // whole DONE cycle and then hold until the next scan completes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ship    <= '0;
         r_field   <= '0;
         r_row     <= '0;
         r_w_hit   <= 1'b0;
         r_w_row   <= '0;
         r_w_col   <= '0;
         r_hit     <= 1'b0;
         r_hit_row <= '0;
         r_hit_col <= '0;
      end else if (w_accept) begin
         r_ship  <= bus.ship;
         r_field <= bus.field;
         r_row   <= '0;
         r_w_hit <= 1'b0;
         r_w_row <= '0;
         r_w_col <= '0;
      end else if (r_state == ST_SCAN) begin
         r_w_hit <= w_nxt_hit;
         r_w_row <= w_nxt_row;
         r_w_col <= w_nxt_col;
         r_row   <= w_last_row ? '0 : r_row + RW'(1);
         if (w_last_row) begin
            r_hit     <= w_nxt_hit;
            r_hit_row <= w_nxt_row;
            r_hit_col <= w_nxt_col;
         end
      end
   end

   assign bus.busy    = (r_state == ST_SCAN);
   assign bus.done    = (r_state == ST_DONE);
   assign bus.hit     = r_hit;
   assign bus.hit_row = r_hit_row;
   assign bus.hit_col = r_hit_col;
endmodule
